// File: rtl/receiver_top_module_pkg.sv
// Shared UART definitions: FSM states, control/status field positions, latched frame config.
package receiver_top_module_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    // Control register fields (shared with the transmitter)
    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_BITS_LSB  = 1;
    localparam int unsigned CTRL_PAR       = 5;
    localparam int unsigned CTRL_STOP_LSB  = 6;

    // Status register fields
    localparam int unsigned STAT_READY     = 0;
    localparam int unsigned STAT_PERR      = 1;
    localparam int unsigned STAT_FERR      = 2;
    localparam int unsigned STAT_OVR       = 3;
    localparam int unsigned STAT_BUSY      = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_e;

    typedef struct packed {
        logic [2:0] last_idx;   // index of the final data bit (data bits - 1)
        logic       par_en;
        logic       two_stop;
    } rx_cfg_t;

    // Decode the frame format; unsupported data-bit counts fall back to 8
    function automatic rx_cfg_t decode_cfg(input logic [7:0] ctrl);
        rx_cfg_t    cfg;
        logic [3:0] nbits;
        nbits         = ctrl[CTRL_BITS_LSB +: 4];
        cfg.last_idx  = (nbits >= 4'd5 && nbits <= 4'd8) ? 3'(nbits - 4'd1) : 3'd7;
        cfg.par_en    = ctrl[CTRL_PAR];
        cfg.two_stop  = (ctrl[CTRL_STOP_LSB +: 2] == 2'd2);
        return cfg;
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Fractional-accumulator oversampled baud tick generator.
module uart_baud_tick_gen
    import receiver_top_module_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] baud,
    output logic        tick
);

    localparam int unsigned ACC_W = 40;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_c;
    logic [ACC_W-1:0] sum_c;
    logic [ACC_W-1:0] mod_c;

    // Per-clock increment and tentative accumulator value
    always_comb begin
        inc_c = ACC_W'(baud) * ACC_W'(OVERSAMPLE);
        mod_c = ACC_W'(CLK_FREQ);
        sum_c = acc_q + inc_c;
    end

    // Accumulate; wrap modulo CLK_FREQ and emit one tick per wrap
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_q <= '0;
            tick  <= 1'b0;
        end else if (inc_c >= mod_c) begin
            acc_q <= '0;
            tick  <= 1'b1;
        end else if (sum_c >= mod_c) begin
            acc_q <= sum_c - mod_c;
            tick  <= 1'b1;
        end else begin
            acc_q <= sum_c;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/receiver_top_module.sv
// UART receiver: synchroniser, frame FSM, shift register and register-style outputs.
module receiver_top_module
    import receiver_top_module_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Baud_Rate_Holding_Register,
    input  logic [31:0] Receiver_Control,
    input  logic        Data_Read,
    input  logic        RX,
    output logic [31:0] Receiver_Buffer_Register,
    output logic [31:0] Receiver_Status
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;

    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic              rx_fall_c, enable_c, sample_c, tick;
    logic [TICK_W-1:0] tick_cnt_q;
    rx_state_e         state_q, state_d;
    rx_cfg_t           cfg_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] data_q, buf_q;
    logic              par_err_q, frame_err_q;
    logic              start_c, shift_c, parity_c, stop_c, load_c;
    logic              ready_q, perr_q, ferr_q, ovr_q, busy_q;
    logic              unused_ctrl;

    assign unused_ctrl = ^Receiver_Control[31:8];
    assign enable_c    = Receiver_Control[CTRL_EN];
    assign rx_fall_c   = rx_prev_q & ~rx_sync_q;
    assign sample_c    = tick && (tick_cnt_q == TICK_W'(OVERSAMPLE / 2 - 1));

    uart_baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (start_c),
        .baud  (Baud_Rate_Holding_Register),
        .tick  (tick)
    );

    // Two-flop synchroniser plus previous-value flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Oversample tick counter, phase-aligned to the start edge
    always_ff @(posedge clk) begin
        if (rst || start_c) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt_q + TICK_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; dropping enable abandons the frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (rx_fall_c) state_d = ST_START;
            ST_START:  if (sample_c) state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            ST_DATA:   if (sample_c && bit_cnt_q == cfg_q.last_idx)
                           state_d = cfg_q.par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (sample_c) state_d = ST_STOP;
            ST_STOP:   if (sample_c) state_d = cfg_q.two_stop ? ST_STOP2 : ST_IDLE;
            ST_STOP2:  if (sample_c) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (!enable_c) state_d = ST_IDLE;
    end

    // FSM output strobes for the datapath
    always_comb begin
        start_c  = 1'b0;
        shift_c  = 1'b0;
        parity_c = 1'b0;
        stop_c   = 1'b0;
        load_c   = 1'b0;
        case (state_q)
            ST_IDLE:   start_c  = rx_fall_c;
            ST_DATA:   shift_c  = sample_c;
            ST_PARITY: parity_c = sample_c;
            ST_STOP: begin
                stop_c = sample_c;
                load_c = sample_c & ~cfg_q.two_stop;
            end
            ST_STOP2: begin
                stop_c = sample_c;
                load_c = sample_c;
            end
            default: ;
        endcase
        if (!enable_c) begin
            start_c  = 1'b0;
            shift_c  = 1'b0;
            parity_c = 1'b0;
            stop_c   = 1'b0;
            load_c   = 1'b0;
        end
    end

    // Frame datapath: latched config, bit counter, shift data, error accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q       <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (start_c) begin
            cfg_q       <= decode_cfg(Receiver_Control[7:0]);
            bit_cnt_q   <= '0;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (shift_c) begin
                data_q[bit_cnt_q] <= rx_sync_q;
                bit_cnt_q         <= bit_cnt_q + BIT_W'(1);
            end
            if (parity_c) par_err_q <= (^data_q) ^ rx_sync_q;
            if (stop_c && !rx_sync_q) frame_err_q <= 1'b1;
        end
    end

    // Output registers: load on frame completion, Data_Read clears ready/overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            if (load_c) begin
                buf_q   <= data_q;
                ready_q <= 1'b1;
                perr_q  <= par_err_q;
                ferr_q  <= frame_err_q | ~rx_sync_q;
                ovr_q   <= ready_q & ~Data_Read;
            end else if (Data_Read) begin
                ready_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
        end
    end

    // Register-style output assembly
    always_comb begin
        Receiver_Buffer_Register             = 32'(buf_q);
        Receiver_Status                      = '0;
        Receiver_Status[STAT_READY]          = ready_q;
        Receiver_Status[STAT_PERR]           = perr_q;
        Receiver_Status[STAT_FERR]           = ferr_q;
        Receiver_Status[STAT_OVR]            = ovr_q;
        Receiver_Status[STAT_BUSY]           = busy_q;
    end

endmodule
